// File: rtl/mem_line_reader_if.sv
// Request/response bus between the line reader and the SDRAM controller.
// The master side issues line reads; the slave side returns data in order.
interface mem_line_reader_if #(
  parameter int addr_width = 20,
  parameter int line_width = 64
) ();
  logic                  enabled;
  logic                  data_ready;
  logic [addr_width-1:0] addr;
  logic                  r_valid;
  logic                  w_valid;
  logic                  rsp_valid;
  logic [line_width-1:0] read;

  modport master (
    input  enabled, data_ready, rsp_valid, read,
    output addr, r_valid, w_valid
  );

  modport slave (
    output enabled, data_ready, rsp_valid, read,
    input  addr, r_valid, w_valid
  );
endinterface

// File: rtl/mem_line_reader.sv
// Streaming line reader: issues sequential credit-limited reads and buffers lines in a FIFO.
// Optional sticky err_o output is enabled by defining MEM_LINE_READER_ERR_EN.
module mem_line_reader #(
  parameter int addr_width = 20,
  parameter int line_width = 64,
  parameter int len_width  = 16,
  parameter int fifo_depth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [addr_width-1:0] start_addr_i,
  input  logic [len_width-1:0]  line_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  mem_line_reader_if.master     mem,
  output logic [line_width-1:0] line_o,
  output logic                  line_valid_o,
  input  logic                  line_ready_i
`ifdef MEM_LINE_READER_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [addr_width-1:0] addr_reg;
  logic [len_width-1:0]  remaining_reg;
  logic [cnt_w-1:0]      outstanding_reg, outstanding_next;
  logic [cnt_w-1:0]      count_reg, count_next;
  logic [ptr_w-1:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [line_width-1:0] fifo_mem [fifo_depth];
  logic [line_width-1:0] head_reg;

  logic start_ok, req_valid, req_accept, push, pop;

  assign start_ok   = (state_reg == ST_IDLE) && start_i;
  // Credits count both lines in flight and lines already buffered.
  assign req_valid  = (state_reg == ST_ISSUE) && mem.enabled &&
                      (remaining_reg != '0) &&
                      ((outstanding_reg + count_reg) < depth_c);
  assign req_accept = req_valid && mem.data_ready;
  assign push       = mem.rsp_valid && (outstanding_reg != '0);
  assign pop        = (count_reg != '0) && line_ready_i;
  assign rd_ptr_inc = rd_ptr_reg + ptr_w'(1);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_accept && !push)
      outstanding_next = outstanding_reg + cnt_one;
    else if (!req_accept && push)
      outstanding_next = outstanding_reg - cnt_one;
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + cnt_one;
    else if (!push && pop)
      count_next = count_reg - cnt_one;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i)
          state_next = (line_count_i != '0) ? ST_ISSUE : ST_DONE;
      end
      ST_ISSUE: begin
        if (req_accept && (remaining_reg == len_width'(1)))
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((outstanding_next == '0) && (count_next == '0))
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      head_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      if (start_ok) begin
        addr_reg      <= start_addr_i;
        remaining_reg <= line_count_i;
      end else if (req_accept) begin
        addr_reg      <= addr_reg + addr_width'(1);
        remaining_reg <= remaining_reg - len_width'(1);
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_inc;
      // Head register gives first-word-fall-through on top of a registered-read array.
      if (push && ((count_reg == '0) || (pop && (count_reg == cnt_one))))
        head_reg <= mem.read;
      else if (pop && (count_reg > cnt_one))
        head_reg <= fifo_mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= mem.read;
  end

`ifdef MEM_LINE_READER_ERR_EN
  logic err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      err_reg <= 1'b0;
    else if (start_ok)
      err_reg <= 1'b0;
    else if ((mem.rsp_valid && (outstanding_reg == '0)) || (!mem.enabled && busy_o))
      err_reg <= 1'b1;
  end

  assign err_o = err_reg;
`endif

  assign busy_o       = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
  assign done_o       = (state_reg == ST_DONE);
  assign line_o       = head_reg;
  assign line_valid_o = (count_reg != '0);
  assign mem.addr     = addr_reg;
  assign mem.r_valid  = req_valid;
  assign mem.w_valid  = 1'b0;

endmodule

// File: tb/tb_mem_line_reader.sv
// Bench for mem_line_reader: table of transfers, hand-written corner sequences and
// randomized transfers checked against an address-sequence model with an in-order memory.
`timescale 1ns/1ps
module tb_mem_line_reader;
  localparam int AW    = 20;
  localparam int LW    = 64;
  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] line_count = '0;
  logic          busy, done, line_valid;
  logic          line_ready = 1'b0;
  logic [LW-1:0] line;
`ifdef MEM_LINE_READER_ERR_EN
  logic          err;
`endif

  mem_line_reader_if #(.addr_width(AW), .line_width(LW)) mem_bus ();

  mem_line_reader #(
    .addr_width(AW), .line_width(LW), .len_width(CW), .fifo_depth(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .line_count_i (line_count),
    .busy_o       (busy),
    .done_o       (done),
    .mem          (mem_bus),
    .line_o       (line),
    .line_valid_o (line_valid),
    .line_ready_i (line_ready)
`ifdef MEM_LINE_READER_ERR_EN
    ,
    .err_o        (err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int dr_pct = 100, lr_pct = 100, en_pct = 100, lat = 1;
  bit resp_hold = 0, rand_all = 0, start_pulse = 0;
  logic [AW-1:0] pulse_addr = '0;
  logic [CW-1:0] pulse_cnt = '0;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;
  rsp_t          rsp_q[$];
  int            last_due = -1;
  logic [AW-1:0] pop_q[$];
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] exp_next_addr = '0;
  int            exp_remaining = 0;
  int req_cnt = 0, pop_cnt = 0, done_cnt = 0, rv_cnt = 0, lv_cnt = 0;
  int first_rv_cyc = -1, last_req_cyc = -1, done_cyc = -1, start_cyc = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  typedef struct {
    logic [AW-1:0] addr;
    int count;
    int lat;
    int dr;
    int lr;
    int exp_reqs;
    int exp_lines;
    int exp_done_delay;
    int exp_span;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [LW-1:0] line_data(logic [AW-1:0] a);
    return {12'hA5C, a, 12'h3B7, ~a};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int d;
    if (!rst_n) begin
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_line_valid", 64'(line_valid), 0);
      check("rst_line", line, 0);
      check("rst_r_valid", 64'(mem_bus.r_valid), 0);
      check("rst_w_valid", 64'(mem_bus.w_valid), 0);
      check("rst_addr", 64'(mem_bus.addr), 0);
`ifdef MEM_LINE_READER_ERR_EN
      check("rst_err", 64'(err), 0);
`endif
      return;
    end
    if (mem_bus.r_valid) begin
      rv_cnt++;
      if (first_rv_cyc < 0) first_rv_cyc = cyc;
    end
    if (!mem_bus.enabled) check("rv_while_disabled", 64'(mem_bus.r_valid), 0);
    if (prev_stall && mem_bus.enabled) begin
      check("stall_valid_stable", 64'(mem_bus.r_valid), 1);
      check("stall_addr_stable", 64'(mem_bus.addr), 64'(prev_addr));
    end
    prev_stall = mem_bus.r_valid && !mem_bus.data_ready;
    prev_addr  = mem_bus.addr;
    if (mem_bus.r_valid && mem_bus.data_ready) begin
      check("req_addr", 64'(mem_bus.addr), 64'(exp_next_addr));
      check("req_credit", 64'((req_cnt - pop_cnt) < DEPTH), 1);
      check("req_extra", 64'(exp_remaining > 0), 1);
      req_log.push_back(mem_bus.addr);
      pop_q.push_back(mem_bus.addr);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      rsp_q.push_back('{mem_bus.addr, d});
      exp_next_addr = exp_next_addr + AW'(1);
      exp_remaining--;
      req_cnt++;
      last_req_cyc = cyc;
    end
    if (line_valid && line_ready) begin
      if (pop_q.size() == 0) check("pop_unexpected", 64'(line_valid), 0);
      else check("pop_data", line, line_data(pop_q.pop_front()));
      pop_cnt++;
    end
    if (line_valid) lv_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_busy_low", 64'(busy), 0);
    end
    check("w_valid_zero", 64'(mem_bus.w_valid), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_all) begin
      start                = 1'($urandom);
      start_addr           = AW'($urandom);
      line_count           = CW'($urandom);
      mem_bus.enabled      = 1'($urandom);
      mem_bus.data_ready   = 1'($urandom);
      mem_bus.rsp_valid    = 1'($urandom);
      mem_bus.read         = {$urandom, $urandom};
      line_ready           = 1'($urandom);
    end else begin
      start       = start_pulse;
      start_pulse = 0;
      start_addr  = pulse_addr;
      line_count  = pulse_cnt;
      mem_bus.enabled    = ($urandom_range(99) < en_pct);
      mem_bus.data_ready = ($urandom_range(99) < dr_pct);
      line_ready         = ($urandom_range(99) < lr_pct);
      if (!resp_hold && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        mem_bus.rsp_valid = 1'b1;
        mem_bus.read      = line_data(rsp_q[0].addr);
        rsp_q.delete(0);
      end else begin
        mem_bus.rsp_valid = 1'b0;
        mem_bus.read      = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    monitor();
    cyc++;
  endtask

  task automatic begin_xfer(logic [AW-1:0] a, int n, int l);
    lat = l;
    pulse_addr = a;
    pulse_cnt = CW'(n);
    start_pulse = 1;
    exp_next_addr = a;
    exp_remaining = n;
    req_cnt = 0; pop_cnt = 0; done_cnt = 0; rv_cnt = 0; lv_cnt = 0;
    first_rv_cyc = -1; last_req_cyc = -1; done_cyc = -1;
    req_log.delete();
    start_cyc = cyc;
    tick();
  endtask

  task automatic wait_done(string name, int max_cycles);
    for (int i = 0; i < max_cycles && done_cnt == 0; i++) tick();
    repeat (3) tick();
    check({name, "_done_pulses"}, 64'(done_cnt), 1);
    check({name, "_busy_after"}, 64'(busy), 0);
    check({name, "_lines_left"}, 64'(pop_q.size()), 0);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    rand_all = 1;
    resp_hold = 1;
    repeat (n) tick();
    rand_all = 0;
    tick();
    rst_n = 1'b1;
    prev_stall = 0;
    pop_q.delete();
    exp_remaining = 0;
    req_cnt = 0; pop_cnt = 0; lv_cnt = 0; done_cnt = 0;
    resp_hold = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wrap_exp [4];
    int n;

    vecs[0] = '{20'h00010,  4, 5, 100, 100,  4,  4, 0,  3};
    vecs[1] = '{20'h12345,  0, 3, 100, 100,  0,  0, 1, -1};
    vecs[2] = '{20'h00000,  1, 1, 100, 100,  1,  1, 0,  0};
    vecs[3] = '{20'h7FFF0,  8, 2, 100, 100,  8,  8, 0,  7};
    vecs[4] = '{20'h0ABCD, 16, 4,  60,  40, 16, 16, 0, -1};
    vecs[5] = '{20'hFFFFF,  3, 7,  70,  70,  3,  3, 0, -1};
    wrap_exp[0] = 20'hFFFFE;
    wrap_exp[1] = 20'hFFFFF;
    wrap_exp[2] = 20'h00000;
    wrap_exp[3] = 20'h00001;

    mem_bus.enabled = 1'b0;
    mem_bus.data_ready = 1'b0;
    mem_bus.rsp_valid = 1'b0;
    mem_bus.read = '0;

    // Reset with random inputs
    do_reset(5);
    tick();
    check("post_reset_line_valid", 64'(line_valid), 0);
    check("post_reset_busy", 64'(busy), 0);

    // Table-driven transfers
    for (int v = 0; v < 6; v++) begin
      dr_pct = vecs[v].dr;
      lr_pct = vecs[v].lr;
      en_pct = 100;
      begin_xfer(vecs[v].addr, vecs[v].count, vecs[v].lat);
      wait_done($sformatf("vec%0d", v), 2000);
      check($sformatf("vec%0d_reqs", v), 64'(req_cnt), 64'(vecs[v].exp_reqs));
      check($sformatf("vec%0d_lines", v), 64'(pop_cnt), 64'(vecs[v].exp_lines));
      check($sformatf("vec%0d_rv_seen", v), 64'(rv_cnt != 0), 64'(vecs[v].count != 0));
      if (vecs[v].exp_done_delay != 0)
        check($sformatf("vec%0d_done_delay", v), 64'(done_cyc - start_cyc), 64'(vecs[v].exp_done_delay));
      if (vecs[v].count > 0)
        check($sformatf("vec%0d_first_req", v), 64'(first_rv_cyc - start_cyc), 1);
      if (vecs[v].exp_span >= 0)
        check($sformatf("vec%0d_req_span", v), 64'(last_req_cyc - first_rv_cyc), 64'(vecs[v].exp_span));
`ifdef MEM_LINE_READER_ERR_EN
      check($sformatf("vec%0d_err", v), 64'(err), 0);
`endif
      $display("[TB] vec%0d addr=%05h count=%0d reqs=%0d lines=%0d done=%0d",
               v, vecs[v].addr, vecs[v].count, req_cnt, pop_cnt, done_cnt);
    end

    // Backpressure: credits stop issue at the buffer depth
    dr_pct = 100; lr_pct = 0; en_pct = 100;
    begin_xfer(20'h00200, 20, 3);
    repeat (30) tick();
    check("bp_reqs_capped", 64'(req_cnt), DEPTH);
    check("bp_buffer_full", 64'(line_valid), 1);
    rv_cnt = 0;
    pulse_addr = 20'h55555;
    pulse_cnt = 16'd3;
    start_pulse = 1;
    repeat (20) tick();
    check("bp_rv_held_low", 64'(rv_cnt), 0);
    check("bp_no_pops", 64'(pop_cnt), 0);
    lr_pct = 100;
    wait_done("bp", 1000);
    check("bp_total_reqs", 64'(req_cnt), 20);
    check("bp_total_lines", 64'(pop_cnt), 20);
    $display("[TB] backpressure reqs=%0d lines=%0d", req_cnt, pop_cnt);

    // Wrap with a stalled first request
    dr_pct = 0; lr_pct = 100;
    begin_xfer(20'hFFFFE, 4, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wrap_stall_valid", 64'(mem_bus.r_valid), 1);
      check("wrap_stall_addr", 64'(mem_bus.addr), 64'(20'hFFFFE));
    end
    dr_pct = 100;
    wait_done("wrap", 500);
    check("wrap_req_count", 64'(req_log.size()), 4);
    n = (req_log.size() < 4) ? req_log.size() : 4;
    for (int i = 0; i < n; i++)
      check($sformatf("wrap_req%0d", i), 64'(req_log[i]), 64'(wrap_exp[i]));
    $display("[TB] wrap reqs=%0d lines=%0d", req_cnt, pop_cnt);

    // Randomized transfers
    for (int r = 0; r < 12; r++) begin
      int cnt;
      cnt = int'($urandom_range(1, 30));
      dr_pct = int'($urandom_range(30, 100));
      lr_pct = int'($urandom_range(20, 100));
      en_pct = 90;
      begin_xfer(AW'($urandom), cnt, int'($urandom_range(1, 8)));
      wait_done($sformatf("rnd%0d", r), 4000);
      check($sformatf("rnd%0d_reqs", r), 64'(req_cnt), 64'(cnt));
      check($sformatf("rnd%0d_lines", r), 64'(pop_cnt), 64'(cnt));
      $display("[TB] rnd%0d count=%0d reqs=%0d lines=%0d", r, cnt, req_cnt, pop_cnt);
    end

    // Reset with three lines outstanding, then stale responses
    dr_pct = 100; lr_pct = 100; en_pct = 100;
    rsp_q.delete();
    begin_xfer(20'h00400, 10, 40);
    for (int i = 0; i < 20 && req_cnt < 3; i++) tick();
    dr_pct = 0;
    tick();
    check("mid_pre_reset_reqs", 64'(req_cnt), 3);
    do_reset(4);
    repeat (60) tick();
    check("mid_stale_delivered", 64'(rsp_q.size()), 0);
    check("mid_line_valid_never", 64'(lv_cnt), 0);
    check("mid_no_pops", 64'(pop_cnt), 0);
    check("mid_busy", 64'(busy), 0);
`ifdef MEM_LINE_READER_ERR_EN
    check("mid_err_set", 64'(err), 1);
`endif
    $display("[TB] reset_mid stale_left=%0d line_valid_cycles=%0d", rsp_q.size(), lv_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
